scramble_sequencer: RTL and testbench

Game-mode controller for the tile puzzle. A scramble button press makes it request MOVES random values from the random-number source and issue each one to the board datapath as a move over a valid/ready handshake. It then waits in the solve phase until the board reports solved, and drives the buzzer for a fixed time. It sits between the button and debounce logic, the random generator and the board move logic, and drives the top-level mix_state and buzzer signals.

---
 rtl/scramble_sequencer.sv | 111 +++++++++++
 tb/tb_scramble_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/scramble_sequencer.sv
// Scramble/solve/buzz game-mode controller: fetches MOVES random codes and issues them as board moves.
// Latency: outputs are Moore-decoded from registered state; no input-to-output combinational path.
// Backpressure: rand_req holds until rand_valid, move_valid/move_data hold until move_ready.
module scramble_sequencer #(
    parameter int MOVES       = 31,
    parameter int RAND_W      = 4,
    parameter int BUZZ_CYCLES = 100_000_000,
    localparam int CW         = (MOVES > 0) ? $clog2(MOVES + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scramble_btn,
    input  logic              solved,
    output logic              rand_req,
    input  logic              rand_valid,
    input  logic [RAND_W-1:0] rand_data,
    output logic              move_valid,
    output logic [RAND_W-1:0] move_data,
    input  logic              move_ready,
    output logic              mix_state,
    output logic              buzz,
    output logic [CW-1:0]     moves_left
);

    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        MOVE  = 3'd2,
        SOLVE = 3'd3,
        BUZZ  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              btn_q;
    logic              btn_edge;
    logic [CW-1:0]     moves_nxt;
    logic [RAND_W-1:0] data_nxt;
    logic [BW-1:0]     buzz_cnt, buzz_cnt_nxt;

    // btn_q resets high so a button held through reset does not count as a press.
    assign btn_edge = scramble_btn & ~btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            btn_q      <= 1'b1;
            moves_left <= '0;
            move_data  <= '0;
            buzz_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            btn_q      <= scramble_btn;
            moves_left <= moves_nxt;
            move_data  <= data_nxt;
            buzz_cnt   <= buzz_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        moves_nxt    = moves_left;
        data_nxt     = move_data;
        buzz_cnt_nxt = buzz_cnt;
        case (state)
            IDLE: begin
                if (btn_edge) begin
                    moves_nxt = CW'(MOVES);
                    state_nxt = (MOVES == 0) ? SOLVE : REQ;
                end
            end
            REQ: begin
                if (rand_valid) begin
                    data_nxt  = rand_data;
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (move_ready) begin
                    moves_nxt = moves_left - 1'b1;
                    state_nxt = (moves_left == CW'(1)) ? SOLVE : REQ;
                end
            end
            SOLVE: begin
                // A fresh press reshuffles even if the board happens to be solved.
                if (btn_edge) begin
                    moves_nxt = CW'(MOVES);
                    state_nxt = (MOVES == 0) ? SOLVE : REQ;
                end else if (solved) begin
                    buzz_cnt_nxt = BW'(BUZZ_CYCLES - 1);
                    state_nxt    = BUZZ;
                end
            end
            BUZZ: begin
                if (buzz_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    buzz_cnt_nxt = buzz_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rand_req   = (state == REQ);
    assign move_valid = (state == MOVE);
    assign mix_state  = (state == REQ) || (state == MOVE);
    assign buzz       = (state == BUZZ);

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer with MOVES=3, RAND_W=4, BUZZ_CYCLES=8.
module tb_scramble_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scramble_btn;
    logic       solved;
    logic       rand_req;
    logic       rand_valid;
    logic [3:0] rand_data;
    logic       move_valid;
    logic [3:0] move_data;
    logic       move_ready;
    logic       mix_state;
    logic       buzz;
    logic [1:0] moves_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scramble_sequencer #(
        .MOVES      (3),
        .RAND_W     (4),
        .BUZZ_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scramble_btn(scramble_btn),
        .solved      (solved),
        .rand_req    (rand_req),
        .rand_valid  (rand_valid),
        .rand_data   (rand_data),
        .move_valid  (move_valid),
        .move_data   (move_data),
        .move_ready  (move_ready),
        .mix_state   (mix_state),
        .buzz        (buzz),
        .moves_left  (moves_left)
    );

    typedef struct packed {
        logic       btn;
        logic       slv;
        logic       rv;
        logic [3:0] rd;
        logic       mr;
        logic       req;
        logic       mv;
        logic [3:0] md;
        logic       mix;
        logic       bz;
        logic [1:0] ml;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl [NV];

    function automatic vec_t mk(input int b, input int s, input int rv, input int rd, input int mr,
                                input int req, input int mv, input int md, input int mix,
                                input int bz, input int ml);
        vec_t v;
        v.btn = b[0];   v.slv = s[0];  v.rv = rv[0]; v.rd = rd[3:0]; v.mr = mr[0];
        v.req = req[0]; v.mv  = mv[0]; v.md = md[3:0]; v.mix = mix[0]; v.bz = bz[0];
        v.ml  = ml[1:0];
        return v;
    endfunction

    // {rand_req, move_valid, move_data, mix_state, buzz, moves_left}
    function automatic logic [9:0] outs();
        return {rand_req, move_valid, move_data, mix_state, buzz, moves_left};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/mv/md/mix/bz/ml=%b required %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic s, input logic rv, input logic [3:0] rd,
                         input logic mr);
        scramble_btn = b; solved = s; rand_valid = rv; rand_data = rd; move_ready = mr;
    endtask

    initial begin
        //               b s rv rd  mr  req mv md  mix bz ml
        tbl[0]  = mk(1, 0, 0, 0,  0,  1, 0, 0,  1, 0, 3);
        tbl[1]  = mk(1, 0, 1, 5,  0,  0, 1, 5,  1, 0, 3);
        tbl[2]  = mk(0, 0, 0, 0,  1,  1, 0, 5,  1, 0, 2);
        tbl[3]  = mk(0, 0, 1, 10, 0,  0, 1, 10, 1, 0, 2);
        tbl[4]  = mk(0, 0, 0, 0,  1,  1, 0, 10, 1, 0, 1);
        tbl[5]  = mk(0, 0, 1, 3,  0,  0, 1, 3,  1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0,  1,  0, 0, 3,  0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[10] = mk(1, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 1, 0);
        tbl[15] = mk(0, 0, 1, 15, 0,  0, 0, 3,  0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,  0,  0, 0, 3,  0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0,  0,  1, 0, 3,  1, 0, 3);
        tbl[18] = mk(0, 0, 0, 0,  0,  1, 0, 3,  1, 0, 3);
        tbl[19] = mk(0, 0, 0, 0,  0,  1, 0, 3,  1, 0, 3);
        tbl[20] = mk(0, 0, 0, 0,  0,  1, 0, 3,  1, 0, 3);
        tbl[21] = mk(0, 0, 1, 7,  0,  0, 1, 7,  1, 0, 3);
        tbl[22] = mk(0, 0, 0, 0,  0,  0, 1, 7,  1, 0, 3);
        tbl[23] = mk(0, 0, 0, 0,  0,  0, 1, 7,  1, 0, 3);
        tbl[24] = mk(0, 0, 0, 0,  0,  0, 1, 7,  1, 0, 3);
        tbl[25] = mk(0, 0, 0, 0,  0,  0, 1, 7,  1, 0, 3);
        tbl[26] = mk(0, 0, 0, 0,  1,  1, 0, 7,  1, 0, 2);
        tbl[27] = mk(0, 0, 1, 9,  0,  0, 1, 9,  1, 0, 2);
        tbl[28] = mk(1, 0, 0, 0,  0,  0, 1, 9,  1, 0, 2);
        tbl[29] = mk(0, 0, 0, 0,  1,  1, 0, 9,  1, 0, 1);
        tbl[30] = mk(0, 0, 1, 2,  0,  0, 1, 2,  1, 0, 1);
        tbl[31] = mk(0, 0, 0, 0,  1,  0, 0, 2,  0, 0, 0);
        tbl[32] = mk(1, 1, 0, 0,  0,  1, 0, 2,  1, 0, 3);
        tbl[33] = mk(0, 0, 1, 4,  0,  0, 1, 4,  1, 0, 3);

        // Reset with the button held: outputs must be zero before any clock edge.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("reset_async", outs(), 10'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("held_btn_no_req_%0d", i), outs(), 10'b0);
        end
        scramble_btn = 1'b0;
        @(posedge clk); #1;
        check("btn_release_idle", outs(), 10'b0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].btn, tbl[i].slv, tbl[i].rv, tbl[i].rd, tbl[i].mr);
            @(posedge clk); #1;
            check($sformatf("vec_%0d", i), outs(),
                  {tbl[i].req, tbl[i].mv, tbl[i].md, tbl[i].mix, tbl[i].bz, tbl[i].ml});
        end

        // Async reset while in MOVE, between clock edges.
        drive(1'b0, 1'b0, 1'b1, 4'h6, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("midmove_reset_async", outs(), 10'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_quiet_%0d", i), outs(), 10'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
